// File: rtl/rle_dec.sv
// Run-length decoder: expands {bit ID, count} run words into bits, packs them LSB-first into bytes.
// Optional macro RLE_DEC_PAD_LAST_EN: pad a flushed partial byte with the last bit ID instead of 0.
module rle_dec #(
  parameter int COUNT_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             recv_ready,
  input  logic             send_ready,
  input  logic [COUNT_W:0] in_data,
  input  logic             end_of_stream,
  output logic             rd_req,
  output logic             wr_req,
  output logic [7:0]       out_data,
  output logic             done
);

  typedef enum logic [3:0] {
    INIT,
    REQUEST_INPUT,
    WAIT_INPUT,
    READ_INPUT,
    EXPAND,
    WRITE_WAIT,
    WAIT_OUTPUT,
    FLUSH,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 value_q, value_d;
  logic [COUNT_W-1:0]   remaining_q, remaining_d;
  logic [7:0]           byte_buf_q, byte_buf_d;
  logic [3:0]           bit_pos_q, bit_pos_d;
  logic                 flushing_q, flushing_d;
  logic                 rd_req_q, rd_req_d;
  logic                 wr_req_q, wr_req_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 done_q, done_d;
  logic                 pad_bit;

`ifdef RLE_DEC_PAD_LAST_EN
  assign pad_bit = value_q;
`else
  assign pad_bit = 1'b0;
`endif

  // Request strobes are registered on the transition so each is high for
  // exactly the one cycle spent in WAIT_INPUT / WAIT_OUTPUT.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    remaining_d = remaining_q;
    byte_buf_d  = byte_buf_q;
    bit_pos_d   = bit_pos_q;
    flushing_d  = flushing_q;
    out_data_d  = out_data_q;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      INIT: begin
        value_d     = 1'b0;
        remaining_d = '0;
        byte_buf_d  = '0;
        bit_pos_d   = '0;
        flushing_d  = 1'b0;
        state_d     = REQUEST_INPUT;
      end
      REQUEST_INPUT: begin
        if (recv_ready) begin
          state_d  = WAIT_INPUT;
          rd_req_d = 1'b1;
        end else if (end_of_stream && (bit_pos_q != 4'd0)) begin
          state_d = FLUSH;
        end else if (end_of_stream) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      WAIT_INPUT: begin
        state_d = READ_INPUT;
      end
      READ_INPUT: begin
        value_d     = in_data[COUNT_W];
        remaining_d = in_data[COUNT_W-1:0];
        if (in_data[COUNT_W-1:0] == '0) begin
          state_d = REQUEST_INPUT;
        end else begin
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        byte_buf_d[bit_pos_q[2:0]] = value_q;
        bit_pos_d   = bit_pos_q + 4'd1;
        remaining_d = remaining_q - COUNT_W'(1);
        if (bit_pos_q == 4'd7) begin
          state_d = WRITE_WAIT;
        end else if (remaining_q == COUNT_W'(1)) begin
          state_d = REQUEST_INPUT;
        end
      end
      WRITE_WAIT: begin
        out_data_d = byte_buf_q;
        if (send_ready) begin
          state_d  = WAIT_OUTPUT;
          wr_req_d = 1'b1;
        end
      end
      WAIT_OUTPUT: begin
        byte_buf_d = '0;
        bit_pos_d  = '0;
        if (flushing_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (remaining_q != '0) begin
          state_d = EXPAND;
        end else begin
          state_d = REQUEST_INPUT;
        end
      end
      FLUSH: begin
        for (int i = 0; i < 8; i++) begin
          if (4'(i) >= bit_pos_q) begin
            byte_buf_d[i] = pad_bit;
          end
        end
        flushing_d = 1'b1;
        state_d    = WRITE_WAIT;
      end
      DONE: begin
        done_d = 1'b1;
        if (!end_of_stream) begin
          state_d = INIT;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      value_q     <= 1'b0;
      remaining_q <= '0;
      byte_buf_q  <= '0;
      bit_pos_q   <= '0;
      flushing_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      remaining_q <= remaining_d;
      byte_buf_q  <= byte_buf_d;
      bit_pos_q   <= bit_pos_d;
      flushing_q  <= flushing_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign rd_req   = rd_req_q;
  assign wr_req   = wr_req_q;
  assign out_data = out_data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rle_dec.sv
// Directed testbench for rle_dec: a small FIFO model feeds run words and logs every written byte.
module tb_rle_dec;

  logic        clk;
  logic        rst;
  logic        recv_ready;
  logic        send_ready;
  logic [23:0] in_data;
  logic        end_of_stream;
  logic        rd_req;
  logic        wr_req;
  logic [7:0]  out_data;
  logic        done;

  rle_dec #(.COUNT_W(23)) dut (
    .clk           (clk),
    .rst           (rst),
    .recv_ready    (recv_ready),
    .send_ready    (send_ready),
    .in_data       (in_data),
    .end_of_stream (end_of_stream),
    .rd_req        (rd_req),
    .wr_req        (wr_req),
    .out_data      (out_data),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input FIFO model: the bench pushes (wr_ptr), the monitor pops (rd_ptr).
  logic [23:0] fifo_mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  assign recv_ready = (rd_ptr != wr_ptr);

  logic [7:0] wr_log [0:63];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         overlap_cnt = 0;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef RLE_DEC_PAD_LAST_EN
  localparam logic [7:0] FLUSH_BYTE = 8'hFF;
`else
  localparam logic [7:0] FLUSH_BYTE = 8'h0F;
`endif

  always @(negedge clk) begin
    if (rd_req) begin
      if (rd_ptr != wr_ptr) begin
        in_data = fifo_mem[rd_ptr % 16];
        rd_ptr++;
      end
      rd_cnt++;
    end
    if (wr_req) begin
      wr_log[wr_cnt % 64] = out_data;
      wr_cnt++;
    end
    if (rd_req && wr_req) overlap_cnt++;
  end

  task automatic push_word(input logic bit_id, input int count);
    fifo_mem[wr_ptr % 16] = {bit_id, 23'(count)};
    wr_ptr++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual !== expected) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    check("reset rd_req", int'(rd_req), 0);
    check("reset wr_req", int'(wr_req), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset done", int'(done), 0);
    rst = 1'b0;
    wait_cycles(5);
    check("idle rd_req", int'(rd_req), 0);
    check("idle done", int'(done), 0);
    $display("test_reset: done");
  endtask

  task automatic test_single_byte;
    int rd0, wr0, lat;
    rd0 = rd_cnt; wr0 = wr_cnt; lat = 0;
    @(negedge clk);
    push_word(1'b0, 8);
    while (!wr_req && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("single latency", lat, 12);
    wait_cycles(10);
    check("single rd count", rd_cnt - rd0, 1);
    check("single wr count", wr_cnt - wr0, 1);
    check("single byte", int'(wr_log[wr0 % 64]), 8'h00);
    check("single idle rd_req", int'(rd_req), 0);
    $display("test_single_byte: word {0,8} latency %0d", lat);
  endtask

  task automatic test_multi_run;
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(negedge clk);
    push_word(1'b1, 3);
    push_word(1'b0, 2);
    push_word(1'b1, 3);
    wait_cycles(40);
    check("multi rd count", rd_cnt - rd0, 3);
    check("multi wr count", wr_cnt - wr0, 1);
    check("multi byte", int'(wr_log[wr0 % 64]), 8'hE7);
    $display("test_multi_run: words {1,3},{0,2},{1,3} -> 0x%0h", wr_log[wr0 % 64]);
  endtask

  task automatic test_flush;
    int wr0;
    wr0 = wr_cnt;
    @(negedge clk);
    push_word(1'b1, 12);
    wait_cycles(40);
    check("flush pre-eos wr count", wr_cnt - wr0, 1);
    end_of_stream = 1'b1;
    wait_cycles(20);
    check("flush wr count", wr_cnt - wr0, 2);
    check("flush byte0", int'(wr_log[wr0 % 64]), 8'hFF);
    check("flush byte1", int'(wr_log[(wr0 + 1) % 64]), int'(FLUSH_BYTE));
    check("flush done", int'(done), 1);
    end_of_stream = 1'b0;
    wait_cycles(4);
    check("flush done cleared", int'(done), 0);
    $display("test_flush: word {1,12} + eos -> 0x%0h 0x%0h", wr_log[wr0 % 64], wr_log[(wr0 + 1) % 64]);
  endtask

  task automatic test_zero_word;
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(negedge clk);
    push_word(1'b1, 0);
    push_word(1'b0, 8);
    wait_cycles(30);
    check("zero rd count", rd_cnt - rd0, 2);
    check("zero wr count", wr_cnt - wr0, 1);
    check("zero byte", int'(wr_log[wr0 % 64]), 8'h00);
    $display("test_zero_word: words {1,0},{0,8} -> 0x%0h", wr_log[wr0 % 64]);
  endtask

  task automatic test_backpressure;
    int wr0, seen_wr;
    wr0 = wr_cnt; seen_wr = 0;
    @(negedge clk);
    send_ready = 1'b0;
    push_word(1'b1, 8);
    repeat (20) begin
      @(negedge clk);
      if (wr_req) seen_wr++;
    end
    check("bp wr_req held low", seen_wr, 0);
    check("bp out_data held", int'(out_data), 8'hFF);
    send_ready = 1'b1;
    @(negedge clk);
    check("bp wr_req pulse", int'(wr_req), 1);
    @(negedge clk);
    check("bp wr_req single", int'(wr_req), 0);
    wait_cycles(3);
    check("bp wr count", wr_cnt - wr0, 1);
    $display("test_backpressure: word {1,8} held 20 cycles -> 0x%0h", out_data);
  endtask

  task automatic test_reset_mid;
    int wr0;
    wr0 = wr_cnt;
    @(negedge clk);
    push_word(1'b0, 20);
    wait_cycles(6);
    rst = 1'b1;
    @(negedge clk);
    check("midrst rd_req", int'(rd_req), 0);
    check("midrst wr_req", int'(wr_req), 0);
    check("midrst out_data", int'(out_data), 0);
    check("midrst done", int'(done), 0);
    rst = 1'b0;
    wait_cycles(10);
    check("midrst no write", wr_cnt - wr0, 0);
    push_word(1'b1, 8);
    wait_cycles(30);
    check("midrst wr count", wr_cnt - wr0, 1);
    check("midrst byte", int'(wr_log[wr0 % 64]), 8'hFF);
    $display("test_reset_mid: post-reset word {1,8} -> 0x%0h", wr_log[wr0 % 64]);
  endtask

  task automatic test_no_overlap;
    check("rd/wr overlap", overlap_cnt, 0);
    $display("test_no_overlap: %0d overlapping cycles", overlap_cnt);
  endtask

  initial begin
    rst = 1'b1;
    send_ready = 1'b1;
    end_of_stream = 1'b0;
    in_data = '0;
    test_reset();
    test_single_byte();
    test_multi_run();
    test_flush();
    test_zero_word();
    test_backpressure();
    test_reset_mid();
    test_no_overlap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rle_dec.md
# rle_dec

Run-length decoder for the bit-stream compression path. It sits directly downstream of the run-length encoder. It pops 24-bit run words ({bit ID, 23-bit count}) from the intermediate FIFO, expands each run one bit per cycle, and packs the bits LSB-first into bytes. Completed bytes are pushed to the output-side FIFO, which reconstructs the original 8-bit input stream.

## Interface
- COUNT_W, 23: run-length field width; run word width is COUNT_W+1.
- clk  input  1  global clock; all state changes on its rising edge.
- rst  input  1  reset; one clock, asynchronous, active-high.
- recv_ready  input  1  input FIFO not empty.
- send_ready  input  1  output FIFO not full.
- in_data  input  COUNT_W+1  run word; [COUNT_W] = bit ID, [COUNT_W-1:0] = run count.
- end_of_stream  input  1  no further run words will arrive; flush the partial byte.
- rd_req  output  1  read request to the input FIFO; single-cycle pulse.
- wr_req  output  1  write request to the output FIFO; single-cycle pulse.
- out_data  output  8  decoded byte; bit 0 is the earliest bit in the stream.
- done  output  1  stream fully decoded and flushed.

## Operation
- Registers:
  - value (1 bit).
  - remaining (COUNT_W bits).
  - byte_buf (8 bits).
  - bit_pos (4 bits, 0..8).
  - flushing (1 bit).
- States and transitions:
  - INIT: clear all registers → REQUEST_INPUT.
  - REQUEST_INPUT: recv_ready=1 → WAIT_INPUT, with rd_req high in that cycle. Otherwise end_of_stream=1 and bit_pos≠0 → FLUSH. Otherwise end_of_stream=1 and bit_pos=0 → DONE. Otherwise stay. recv_ready has priority over end_of_stream.
  - WAIT_INPUT: rd_req returns low → READ_INPUT.
  - READ_INPUT: capture value=in_data[COUNT_W] and remaining=in_data[COUNT_W-1:0]. remaining=0 → REQUEST_INPUT (word discarded); otherwise → EXPAND.
  - EXPAND: each cycle, byte_buf[bit_pos]<=value, bit_pos+1, remaining−1. If this fills bit 7 → WRITE_WAIT. Otherwise, if remaining was 1 → REQUEST_INPUT. Otherwise stay.
  - WRITE_WAIT: out_data<=byte_buf. send_ready=1 → WAIT_OUTPUT, with wr_req high in that cycle.
  - WAIT_OUTPUT: wr_req low; clear byte_buf and bit_pos. flushing → DONE; remaining≠0 → EXPAND; otherwise → REQUEST_INPUT.
  - FLUSH: fill byte_buf[7:bit_pos] with the pad bit (see Configuration); set flushing → WRITE_WAIT.
  - DONE: done=1. end_of_stream falling → INIT.
- Runs longer than 8 bits span bytes; remaining persists across WRITE_WAIT/WAIT_OUTPUT.
- Bit ordering matches the encoder: its right-shift emits bit 0 first.

## Timing
- Reset values: rd_req=0, wr_req=0, out_data=0x00, done=0, state=INIT.
- Reset mid-operation: all registers are cleared immediately, including any held byte and remaining count. No request pulse is emitted after reset.
- Read handshake:
  - rd_req is high for exactly one cycle (the WAIT_INPUT cycle).
  - The FIFO registers the request at the end of that cycle.
  - in_data is sampled at the end of the following cycle (READ_INPUT).
- Write handshake:
  - out_data is stable from the cycle after WRITE_WAIT entry through the wr_req cycle.
  - wr_req is high for exactly one cycle.
  - send_ready low holds the block in WRITE_WAIT indefinitely, with no bit loss.
- Latency: run word {x,8} with bit_pos=0 produces wr_req 12 cycles after REQUEST_INPUT is entered, with send_ready=1: 1 + 1 + 1 + 8 + 1.
- Throughput: 1 bit/cycle during EXPAND; overhead of 3 cycles per run word and 2 cycles per byte.
- rd_req and wr_req are never high in the same cycle.
- Maximum run: 2^COUNT_W−1 bits.

## Configuration
- RLE_DEC_PAD_LAST_EN defined: the flush pad bit is value, the last decoded bit ID.
- RLE_DEC_PAD_LAST_EN undefined: the flush pad bit is 0.
- A flush with bit_pos=0 writes nothing in either mode.

## Test plan
- After reset, word {0,8}: exactly one rd_req, one wr_req with out_data=0x00, then the block idles in REQUEST_INPUT.
- Words {1,3}, {0,2}, {1,3}: single write of 0xE7; three rd_req pulses.
- Word {1,12}, then end_of_stream=1: writes 0xFF then 0x0F without the macro, or 0xFF then 0xFF with RLE_DEC_PAD_LAST_EN; done=1 afterwards.
- Word {1,0}, then {0,8}: the zero word is consumed without any bit change; a single write of 0x00 follows.
- Word {1,8} with send_ready held low for 20 cycles: wr_req stays 0 and out_data=0xFF is held; wr_req pulses once one cycle after send_ready rises.
- Word {0,20}, with rst pulsed during EXPAND: rd_req, wr_req, out_data and done read 0 during reset. After release, word {1,8} yields exactly 0xFF with no stale bits.
